// File: rtl/weight_pkg.sv
// Constants and FSM encoding shared by the weight loader and the weight feature module.
package weight_pkg;

    localparam int W_WIDTH = 16;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/weight_beat_unpacker.sv
// One-beat holding buffer that hands out its W_WIDTH-bit words LSB first and
// decides when the next stream beat may be accepted.
module weight_beat_unpacker
    import weight_pkg::*;
#(
    parameter int IN_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                abort_i,
    input  logic                last_i,
    input  logic                s_valid_i,
    input  logic [IN_WIDTH-1:0] s_data_i,
    output logic                s_ready_o,
    output logic                write_o,
    output logic [W_WIDTH-1:0]  word_o
);

    localparam int RATIO = IN_WIDTH / W_WIDTH;
    localparam int SUB_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(RATIO - 1);

    logic [IN_WIDTH-1:0] buf_q, buf_d;
    logic [SUB_W-1:0]    sub_q, sub_d;
    logic                valid_q, valid_d;
    logic                accept;

    // A new beat may land in the same cycle the final word of the old one is
    // written, but never once the load's last word is in the buffer.
    assign s_ready_o = load_i && !abort_i && (!valid_q || (sub_q == SUB_LAST && !last_i));
    assign accept    = s_valid_i && s_ready_o;
    assign write_o   = load_i && !abort_i && valid_q;

    always_comb begin
        word_o = buf_q[W_WIDTH-1:0];
        for (int i = 0; i < RATIO; i++) begin
            if (sub_q == SUB_W'(i)) word_o = buf_q[i*W_WIDTH +: W_WIDTH];
        end
    end

    always_comb begin
        buf_d   = buf_q;
        sub_d   = sub_q;
        valid_d = valid_q;
        if (!load_i || abort_i) begin
            valid_d = 1'b0;
            sub_d   = '0;
        end else begin
            if (write_o) begin
                if (last_i || sub_q == SUB_LAST) begin
                    valid_d = 1'b0;
                    sub_d   = '0;
                end else begin
                    sub_d = sub_q + SUB_W'(1);
                end
            end
            if (accept) begin
                buf_d   = s_data_i;
                valid_d = 1'b1;
                sub_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q   <= '0;
            sub_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            sub_q   <= sub_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/weight_load_ctrl.sv
// Fills one of two weight SRAM banks from a valid/ready stream and tracks
// per-bank "loaded" flags so the consumer can ping-pong between banks.
module weight_load_ctrl
    import weight_pkg::*;
#(
    parameter int IN_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                bank_sel,
    input  logic [ADDR_W:0]     num_words,
    input  logic                abort,
    input  logic                s_valid,
    input  logic [IN_WIDTH-1:0] s_data,
    output logic                s_ready,
    output logic [1:0]          bank_we,
    output logic [ADDR_W-1:0]   bank_addr,
    output logic [W_WIDTH-1:0]  bank_din,
    output logic [1:0]          bank_full,
    input  logic [1:0]          bank_release,
    output logic                done,
    output logic                err
);

    localparam logic [ADDR_W:0] NW_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] NW_ONE   = (ADDR_W + 1)'(1);

    state_e              state_q, state_d;
    logic                bank_q, bank_d;
    logic [ADDR_W:0]     nwords_q, nwords_d;
    logic [ADDR_W-1:0]   wcnt_q, wcnt_d;
    logic [1:0]          we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [W_WIDTH-1:0]  din_q, din_d;
    logic [1:0]          full_q, full_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                write;
    logic                last;
    logic                start_ok;
    logic [W_WIDTH-1:0]  word;

    assign last     = ({1'b0, wcnt_q} == (nwords_q - NW_ONE));
    assign start_ok = (num_words != '0) && (num_words <= NW_DEPTH) && !full_q[bank_sel];

    weight_beat_unpacker #(
        .IN_WIDTH (IN_WIDTH)
    ) u_unpacker (
        .clk       (clk),
        .rst       (rst),
        .load_i    (state_q == LOAD),
        .abort_i   (abort),
        .last_i    (last),
        .s_valid_i (s_valid),
        .s_data_i  (s_data),
        .s_ready_o (s_ready),
        .write_o   (write),
        .word_o    (word)
    );

    // The full flag is raised on the same edge the last word is written, so a
    // release of the other bank in that cycle is applied independently.
    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        nwords_d = nwords_q;
        wcnt_d   = wcnt_q;
        we_d     = 2'b00;
        addr_d   = addr_q;
        din_d    = din_q;
        full_d   = full_q & ~bank_release;
        done_d   = (state_q == DONE);
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        state_d  = LOAD;
                        bank_d   = bank_sel;
                        nwords_d = num_words;
                        wcnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end else if (write) begin
                    we_d   = bank_q ? 2'b10 : 2'b01;
                    addr_d = wcnt_q;
                    din_d  = word;
                    if (last) begin
                        state_d        = DONE;
                        full_d[bank_q] = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + ADDR_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bank_q   <= 1'b0;
            nwords_q <= '0;
            wcnt_q   <= '0;
            we_q     <= '0;
            addr_q   <= '0;
            din_q    <= '0;
            full_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bank_q   <= bank_d;
            nwords_q <= nwords_d;
            wcnt_q   <= wcnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            full_q   <= full_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bank_we   = we_q;
    assign bank_addr = addr_q;
    assign bank_din  = din_q;
    assign bank_full = full_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Scoreboard bench for weight_load_ctrl: expected bank writes are queued as
// beats are accepted and popped by a monitor whenever the DUT writes.
`timescale 1ns/1ps
module tb_weight_load_ctrl;
    import weight_pkg::*;

    localparam int IN_WIDTH = 32;
    localparam int RATIO    = IN_WIDTH / W_WIDTH;

    typedef logic [ADDR_W:0] nw_t;
    typedef struct packed {
        logic [1:0]         we;
        logic [ADDR_W-1:0]  addr;
        logic [W_WIDTH-1:0] din;
    } wr_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                bank_sel = 1'b0;
    logic                abort = 1'b0;
    logic                s_valid = 1'b0;
    nw_t                 num_words = '0;
    logic [IN_WIDTH-1:0] s_data = '0;
    logic [1:0]          bank_release = '0;
    logic                s_ready, done, err;
    logic [1:0]          bank_we, bank_full;
    logic [ADDR_W-1:0]   bank_addr;
    logic [W_WIDTH-1:0]  bank_din;

    wr_t        expQ[$];
    wr_t        monW;
    int         checks = 0;
    int         errors = 0;
    int         expDone = 0;
    int         expErr = 0;
    int         runLen = 0;
    int         lastRun = 0;
    logic       prevWe = 1'b0;
    logic [1:0] fullModel = '0;

    weight_load_ctrl #(.IN_WIDTH(IN_WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bank_sel     (bank_sel),
        .num_words    (num_words),
        .abort        (abort),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .bank_we      (bank_we),
        .bank_addr    (bank_addr),
        .bank_din     (bank_din),
        .bank_full    (bank_full),
        .bank_release (bank_release),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bank_we != 2'b00) begin
                runLen++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_write", {bank_we, bank_addr, bank_din}, '0);
                end else begin
                    monW = expQ.pop_front();
                    checkOutput("bank_write", {bank_we, bank_addr, bank_din}, monW);
                end
            end else if (runLen != 0) begin
                lastRun = runLen;
                runLen  = 0;
            end
            if (done) begin
                if (expDone == 0) begin
                    checkOutput("unexpected_done", done, 0);
                end else begin
                    expDone--;
                    checkOutput("done_after_last_write", {prevWe, expQ.size() == 0}, 2'b11);
                end
            end
            if (err) begin
                if (expErr == 0) begin
                    checkOutput("unexpected_err", err, 0);
                end else begin
                    expErr--;
                    checkOutput("err_without_write", bank_we, 0);
                end
            end
            prevWe = (bank_we != 2'b00);
        end else begin
            prevWe = 1'b0;
            runLen = 0;
        end
    end

    // mode 0: s_valid always high, 1: toggling, 2: random 40% duty
    task automatic applyStimulus(input logic b, input int n, input int mode, input int beatLimit, input bit seqData);
        int need   = (n + RATIO - 1) / RATIO;
        int sent   = 0;
        int pushed = 0;
        int guard  = 0;
        logic [IN_WIDTH-1:0] beat = '0;
        logic acc;
        if (beatLimit < need) need = beatLimit;
        else expDone++;
        @(posedge clk); #1;
        start = 1'b1; bank_sel = b; num_words = nw_t'(n);
        @(posedge clk); #1;
        start = 1'b0;
        while (sent < need && guard < 500) begin
            for (int i = 0; i < RATIO; i++)
                beat[i*W_WIDTH +: W_WIDTH] = seqData ? W_WIDTH'(sent * RATIO + i + 1) : W_WIDTH'($urandom);
            s_data = beat;
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = guard[0];
                default: s_valid = ($urandom_range(99) < 40);
            endcase
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) begin
                for (int i = 0; i < RATIO; i++) begin
                    if (pushed < n) begin
                        expQ.push_back('{we: (b ? 2'b10 : 2'b01), addr: ADDR_W'(pushed),
                                         din: beat[i*W_WIDTH +: W_WIDTH]});
                        pushed++;
                    end
                end
                sent++;
            end
            guard++;
        end
        s_valid = 1'b0;
        if (guard >= 500) checkOutput("beat_timeout", sent, need);
    endtask

    task automatic drainAndCheck(input bit relOther, input logic b);
        bit seen = 0;
        s_valid = 1'b1;
        s_data  = '1;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            checkOutput("s_ready_after_last_beat", s_ready, 0);
            if (done) begin
                seen = 1;
                if (relOther) bank_release = b ? 2'b01 : 2'b10;
            end
        end
        if (!seen) checkOutput("done_timeout", done, 1);
        @(posedge clk); #1;
        s_valid      = 1'b0;
        bank_release = '0;
        fullModel[b] = 1'b1;
        if (relOther) fullModel[!b] = 1'b0;
        @(negedge clk);
        checkOutput("bank_full_after_load", bank_full, fullModel);
    endtask

    task automatic rejectStart(input logic b, input int n);
        expErr++;
        @(posedge clk); #1;
        start = 1'b1; bank_sel = b; num_words = nw_t'(n);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("err_pulse", err, 1);
        @(negedge clk);
        checkOutput("err_one_cycle", err, 0);
        checkOutput("idle_after_reject", s_ready, 0);
    endtask

    task automatic releaseBanks(input logic [1:0] r);
        @(posedge clk); #1;
        bank_release = r;
        @(posedge clk); #1;
        bank_release = '0;
        fullModel &= ~r;
        @(negedge clk);
        checkOutput("bank_full_after_release", bank_full, fullModel);
    endtask

    task automatic abortTest();
        logic [IN_WIDTH-1:0] beats [2];
        int   idx = 0;
        int   seenW = 0;
        bit   aborted = 0;
        logic acc;
        beats[0] = 32'hA002_A001;
        beats[1] = 32'hB002_B001;
        expQ.push_back('{we: 2'b10, addr: ADDR_W'(0), din: 16'hA001});
        expQ.push_back('{we: 2'b10, addr: ADDR_W'(1), din: 16'hA002});
        expQ.push_back('{we: 2'b10, addr: ADDR_W'(2), din: 16'hB001});
        @(posedge clk); #1;
        start = 1'b1; bank_sel = 1'b1; num_words = nw_t'(10);
        @(posedge clk); #1;
        start   = 1'b0;
        s_valid = 1'b1;
        for (int c = 0; c < 40 && !aborted; c++) begin
            s_data = beats[(idx > 1) ? 1 : idx];
            @(negedge clk);
            if (bank_we != 2'b00) seenW++;
            acc = s_ready;
            if (seenW == 3) begin
                abort   = 1'b1;
                s_valid = 1'b0;
                aborted = 1;
                acc     = 1'b0;
            end
            @(posedge clk); #1;
            abort = 1'b0;
            if (acc) idx++;
        end
        s_valid = 1'b0;
        if (!aborted) checkOutput("abort_write_timeout", seenW, 3);
        @(negedge clk);
        checkOutput("we_after_abort", bank_we, 0);
        checkOutput("s_ready_after_abort", s_ready, 0);
        checkOutput("abort_queue_empty", expQ.size(), 0);
        repeat (4) @(negedge clk);
        checkOutput("bank_full_after_abort", bank_full, fullModel);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {s_ready, bank_we, bank_addr, bank_din, bank_full, done, err}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus(1'b0, 16, 0, 16, 1);
        drainAndCheck(1'b0, 1'b0);
        checkOutput("bank0_burst_len", lastRun, 16);

        applyStimulus(1'b1, 5, 0, 16, 1);
        drainAndCheck(1'b0, 1'b1);

        rejectStart(1'b0, 4);
        rejectStart(1'b1, 4);
        releaseBanks(2'b11);
        rejectStart(1'b0, 0);
        rejectStart(1'b1, DEPTH + 1);

        applyStimulus(1'b0, 9, 1, 16, 0);
        drainAndCheck(1'b0, 1'b0);
        releaseBanks(2'b01);

        for (int it = 0; it < 8; it++) begin
            logic bb;
            int   nn;
            int   md;
            bb = 1'($urandom_range(1));
            nn = $urandom_range(DEPTH, 1);
            md = $urandom_range(2);
            applyStimulus(bb, nn, md, 16, 0);
            drainAndCheck(1'b0, bb);
            releaseBanks(2'b11);
        end

        abortTest();
        applyStimulus(1'b1, 4, 0, 16, 1);
        drainAndCheck(1'b0, 1'b1);

        applyStimulus(1'b0, 16, 0, 2, 0);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("reset_midload_outputs", {s_ready, bank_we, bank_addr, bank_din, bank_full, done, err}, 0);
        expQ.delete();
        fullModel = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus(1'b1, 3, 0, 16, 1);
        drainAndCheck(1'b0, 1'b1);
        applyStimulus(1'b0, 2, 0, 16, 1);
        drainAndCheck(1'b1, 1'b0);

        repeat (5) @(negedge clk);
        checkOutput("pending_writes", expQ.size(), 0);
        checkOutput("pending_done", expDone, 0);
        checkOutput("pending_err", expErr, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
